// File: rtl/mfetch_pkg.sv
// mfetch_pkg: shared definitions for the instruction fetch stage.
//   - opcode values seen by fetch (Nop, End)
//   - NOP_PAIR: the bubble shown to decode when no valid word is available
//   - fetch_state_t: fetch FSM encoding
//   - IMEM_ADDR_W_DFLT: default instruction memory word-address width,
//     shared with the memory wrapper
package mfetch_pkg;

  localparam logic [5:0] OPC_NOP = 6'h00;
  localparam logic [5:0] OPC_END = 6'h3F;

  localparam logic [63:0] NOP_PAIR = {OPC_NOP, 26'b0, OPC_NOP, 26'b0};

  localparam int IMEM_ADDR_W_DFLT = 14;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/mfetch.sv
// mfetch: instruction fetch stage feeding decode.
// Owns the fetch PC, drives a synchronous 64-bit instruction memory with a
// one-cycle read latency and presents one {upper, lower} instruction pair
// plus its PC to decode every cycle.
//
// Ports:
//   clk          clock
//   rstn         asynchronous active-low reset
//   interlock    decode cannot accept; pc/inst are held stable
//   branch_flag  one-cycle redirect pulse from decode
//   branch_pc    redirect target (valid with branch_flag)
//   imem_en      instruction memory read enable
//   imem_addr    instruction memory word address
//   imem_dout    instruction memory read data (one cycle after the address)
//   pc           PC of the pair on inst
//   inst         instruction pair to decode
//   halted       high once an End has been accepted by decode
module mfetch
  import mfetch_pkg::*;
#(
  parameter int          IMEM_ADDR_W = IMEM_ADDR_W_DFLT,
  parameter logic [31:0] BOOT_PC     = 32'h0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   interlock,
  input  logic                   branch_flag,
  input  logic [31:0]            branch_pc,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [63:0]            imem_dout,
  output logic [31:0]            pc,
  output logic [63:0]            inst,
  output logic                   halted
);

  fetch_state_t state_q, state_d;
  logic [31:0]  nxt_pc_q, nxt_pc_d;
  logic [31:0]  rd_pc_q, rd_pc_d;
  logic         rd_valid_q, rd_valid_d;

  logic         show;
  logic         halt_accept;

  // The word on imem_dout is only shown while it is a requested word and
  // fetch has not halted; everything else is a bubble.
  assign show   = rd_valid_q && (state_q != HALT);
  assign inst   = show ? imem_dout : NOP_PAIR;
  assign pc     = show ? rd_pc_q : 32'h0;
  assign halted = (state_q == HALT);

  // End counts only when decode actually accepts it; the interlock and
  // branch cases take priority in the next-state logic below.
  assign halt_accept = show && (imem_dout[63:58] == OPC_END);

  // Address mux. While stalled the displayed word is re-read so the
  // synchronous memory output stays stable across the stall.
  always_comb begin
    imem_en   = 1'b1;
    imem_addr = nxt_pc_q[IMEM_ADDR_W-1:0];
    if (state_q == HALT) begin
      imem_en = 1'b0;
    end else if (branch_flag) begin
      imem_addr = branch_pc[IMEM_ADDR_W-1:0];
    end else if (interlock && rd_valid_q) begin
      imem_addr = rd_pc_q[IMEM_ADDR_W-1:0];
    end
  end

  // Next-state logic. A redirect overrides any interlock in the same cycle
  // because decode flushes its input while branching.
  always_comb begin
    state_d    = state_q;
    nxt_pc_d   = nxt_pc_q;
    rd_pc_d    = rd_pc_q;
    rd_valid_d = rd_valid_q;
    if (state_q != HALT) begin
      if (branch_flag) begin
        rd_pc_d    = branch_pc;
        nxt_pc_d   = branch_pc + 32'd1;
        rd_valid_d = 1'b1;
        state_d    = RUN;
      end else if (interlock) begin
        // hold everything, including during BOOT
      end else if (halt_accept) begin
        state_d    = HALT;
        rd_valid_d = 1'b0;
      end else begin
        rd_pc_d    = nxt_pc_q;
        nxt_pc_d   = nxt_pc_q + 32'd1;
        rd_valid_d = 1'b1;
        state_d    = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= BOOT;
      nxt_pc_q   <= BOOT_PC;
      rd_pc_q    <= 32'h0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nxt_pc_q   <= nxt_pc_d;
      rd_pc_q    <= rd_pc_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_mfetch.sv
// tb_mfetch: directed bench for the fetch stage with a behavioural
// synchronous instruction memory.
module tb_mfetch;
  import mfetch_pkg::*;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rstn;
  logic          interlock;
  logic          branch_flag;
  logic [31:0]   branch_pc;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [63:0]   imem_dout;
  logic [31:0]   pc;
  logic [63:0]   inst;
  logic          halted;

  int checks = 0;
  int fails  = 0;

  logic [63:0] mem [0:(1<<AW)-1];

  mfetch #(.IMEM_ADDR_W(AW), .BOOT_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .interlock(interlock), .branch_flag(branch_flag),
    .branch_pc(branch_pc), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_dout(imem_dout), .pc(pc), .inst(inst), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_dout <= mem[imem_addr];

  // Distinct content per word; only word 5 carries an End upper opcode.
  function automatic logic [63:0] word(input int i);
    logic [25:0] lo;
    lo = 26'(i);
    if (i == 5) return {OPC_END, lo, 6'h02, lo};
    return {6'h02, lo, 6'h03, ~lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold_reset();
    rstn = 1'b0; interlock = 1'b0; branch_flag = 1'b0; branch_pc = 32'h0;
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; interlock = 1'b0; branch_flag = 1'b0; branch_pc = 32'h0;
    #1;
    checks++; if (pc !== 32'h0) begin $display("FAIL rst_pc got %h exp 0", pc); fails++; end
    checks++; if (inst !== NOP_PAIR) begin $display("FAIL rst_inst got %h exp %h", inst, NOP_PAIR); fails++; end
    checks++; if (imem_en !== 1'b1) begin $display("FAIL rst_en got %b exp 1", imem_en); fails++; end
    checks++; if (imem_addr !== 14'h0) begin $display("FAIL rst_addr got %h exp 0", imem_addr); fails++; end
    checks++; if (halted !== 1'b0) begin $display("FAIL rst_halted got %b exp 0", halted); fails++; end
    hold_reset();
    checks++; if (inst !== NOP_PAIR) begin $display("FAIL cyc1_inst got %h exp %h", inst, NOP_PAIR); fails++; end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (inst !== word(k) || pc !== 32'(k)) begin
        $display("FAIL seq%0d got %h/%h exp %h/%h", k, inst, pc, word(k), k); fails++; end
    end
  endtask

  task automatic test_interlock();
    interlock = 1'b1;
    #1;
    checks++; if (imem_addr !== 14'd1) begin $display("FAIL stall_addr got %h exp 1", imem_addr); fails++; end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (inst !== word(1) || pc !== 32'd1) begin
        $display("FAIL stall%0d got %h/%h exp %h/1", k, inst, pc, word(1)); fails++; end
      checks++; if (imem_addr !== 14'd1) begin $display("FAIL stall%0d_addr got %h exp 1", k, imem_addr); fails++; end
    end
    interlock = 1'b0;
    #1;
    checks++; if (imem_addr !== 14'd2) begin $display("FAIL unstall_addr got %h exp 2", imem_addr); fails++; end
    tick();
    checks++; if (inst !== word(2) || pc !== 32'd2) begin
      $display("FAIL unstall got %h/%h exp %h/2", inst, pc, word(2)); fails++; end
  endtask

  task automatic test_branch(input logic with_stall, input int tgt);
    branch_flag = 1'b1; interlock = with_stall; branch_pc = 32'(tgt);
    #1;
    checks++; if (imem_addr !== 14'(tgt)) begin $display("FAIL br_addr got %h exp %h", imem_addr, 14'(tgt)); fails++; end
    tick();
    branch_flag = 1'b0; interlock = 1'b0;
    checks++; if (inst !== word(tgt) || pc !== 32'(tgt)) begin
      $display("FAIL br_tgt got %h/%h exp %h/%h", inst, pc, word(tgt), tgt); fails++; end
    tick();
    checks++; if (inst !== word(tgt + 1) || pc !== 32'(tgt + 1)) begin
      $display("FAIL br_next got %h/%h exp %h/%h", inst, pc, word(tgt + 1), tgt + 1); fails++; end
  endtask

  task automatic test_wrap();
    branch_flag = 1'b1; branch_pc = 32'hFFFF_FFFE;
    tick();
    branch_flag = 1'b0;
    checks++; if (inst !== word(16'h3FFE) || pc !== 32'hFFFF_FFFE) begin
      $display("FAIL wrap_fe got %h/%h exp %h/fffffffe", inst, pc, word(16'h3FFE)); fails++; end
    #1;
    checks++; if (imem_addr !== 14'h3FFF) begin $display("FAIL wrap_addr_ff got %h exp 3fff", imem_addr); fails++; end
    tick();
    checks++; if (inst !== word(16'h3FFF) || pc !== 32'hFFFF_FFFF) begin
      $display("FAIL wrap_ff got %h/%h exp %h/ffffffff", inst, pc, word(16'h3FFF)); fails++; end
    #1;
    checks++; if (imem_addr !== 14'h0) begin $display("FAIL wrap_addr0 got %h exp 0", imem_addr); fails++; end
    tick();
    checks++; if (inst !== word(0) || pc !== 32'h0) begin
      $display("FAIL wrap_0 got %h/%h exp %h/0", inst, pc, word(0)); fails++; end
    tick();
    checks++; if (inst !== word(1) || pc !== 32'd1) begin
      $display("FAIL wrap_1 got %h/%h exp %h/1", inst, pc, word(1)); fails++; end
  endtask

  task automatic test_async_reset();
    interlock = 1'b1;
    tick();
    checks++; if (pc !== 32'd1) begin $display("FAIL pre_arst_pc got %h exp 1", pc); fails++; end
    rstn = 1'b0;
    #1;
    checks++; if (inst !== NOP_PAIR || pc !== 32'h0) begin
      $display("FAIL arst_out got %h/%h exp %h/0", inst, pc, NOP_PAIR); fails++; end
    checks++; if (imem_addr !== 14'h0 || imem_en !== 1'b1) begin
      $display("FAIL arst_addr got %h/%b exp 0/1", imem_addr, imem_en); fails++; end
    hold_reset();
    tick();
    checks++; if (inst !== word(0) || pc !== 32'h0) begin
      $display("FAIL arst_restart got %h/%h exp %h/0", inst, pc, word(0)); fails++; end
  endtask

  task automatic test_interlock_boot();
    hold_reset();
    interlock = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (inst !== NOP_PAIR || pc !== 32'h0 || imem_addr !== 14'h0) begin
        $display("FAIL boot_stall%0d got %h/%h/%h exp %h/0/0", k, inst, pc, imem_addr, NOP_PAIR); fails++; end
    end
    interlock = 1'b0;
    tick();
    checks++; if (inst !== word(0) || pc !== 32'h0) begin
      $display("FAIL boot_release got %h/%h exp %h/0", inst, pc, word(0)); fails++; end
  endtask

  task automatic run_to_end();
    hold_reset();
    for (int k = 0; k < 6; k++) tick();
    checks++; if (inst !== word(5) || pc !== 32'd5 || halted !== 1'b0) begin
      $display("FAIL end_shown got %h/%h/%b exp %h/5/0", inst, pc, halted, word(5)); fails++; end
  endtask

  task automatic test_halt();
    run_to_end();
    tick();
    checks++; if (halted !== 1'b1 || inst !== NOP_PAIR || pc !== 32'h0 || imem_en !== 1'b0) begin
      $display("FAIL halt got %b/%h/%h/%b exp 1/%h/0/0", halted, inst, pc, imem_en, NOP_PAIR); fails++; end
    branch_flag = 1'b1; interlock = 1'b1; branch_pc = 32'h30;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (halted !== 1'b1 || inst !== NOP_PAIR || imem_en !== 1'b0) begin
        $display("FAIL halt_hold%0d got %b/%h/%b exp 1/%h/0", k, halted, inst, imem_en, NOP_PAIR); fails++; end
    end
    branch_flag = 1'b0; interlock = 1'b0;
  endtask

  task automatic test_halt_branch();
    run_to_end();
    branch_flag = 1'b1; branch_pc = 32'h20;
    tick();
    branch_flag = 1'b0;
    checks++; if (halted !== 1'b0 || inst !== word(32'h20) || pc !== 32'h20) begin
      $display("FAIL end_branch got %b/%h/%h exp 0/%h/20", halted, inst, pc, word(32'h20)); fails++; end
    tick();
    checks++; if (halted !== 1'b0 || pc !== 32'h21) begin
      $display("FAIL end_branch_next got %b/%h exp 0/21", halted, pc); fails++; end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = word(i);
    test_reset();
    test_interlock();
    test_branch(1'b0, 32'h40);
    test_branch(1'b1, 32'h80);
    test_wrap();
    test_async_reset();
    test_interlock_boot();
    test_halt();
    test_halt_branch();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mfetch.md
Name: mfetch

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Owns the fetch PC and drives a synchronous 64-bit-wide instruction memory (1-cycle read latency).
- Presents one {upper, lower} instruction pair plus its PC to decode each cycle.
- Honours decode's interlock (stall) and branch redirect, and halts on an accepted End.

Parameters:
IMEM_ADDR_W, 14, instruction memory word-address width (one word = one 64-bit pair)
BOOT_PC, 32'h0, first PC fetched after reset

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
interlock  in  1  decode cannot accept this cycle; hold pc/inst stable
branch_flag  in  1  one-cycle redirect pulse from decode (decode flushes its input this cycle)
branch_pc  in  32  redirect target, valid when branch_flag=1
imem_en  out  1  instruction memory read enable
imem_addr  out  IMEM_ADDR_W  instruction memory read address
imem_dout  in  64  read data, valid the cycle after imem_addr/imem_en
pc  out  32  PC of the pair on inst
inst  out  64  instruction pair to decode; [63:58] upper opcode, [31:26] lower opcode
halted  out  1  high once End has been accepted

Behaviour:
- Internal registers:
  - nxt_pc[31:0]: next sequential address.
  - rd_pc[31:0]: PC of the word on imem_dout.
  - rd_valid: imem_dout holds a requested word.
  - state: BOOT, RUN, HALT.
- Async reset (rstn=0), effective immediately:
  - nxt_pc=BOOT_PC, rd_pc=0, rd_valid=0, state=BOOT, halted=0.
  - Outputs: pc=0, inst=NOP_PAIR.
  - imem_en=1, imem_addr=BOOT_PC[IMEM_ADDR_W-1:0].
- Output mux (combinational):
  - rd_valid=1 and state≠HALT: inst=imem_dout, pc=rd_pc.
  - Otherwise: inst=NOP_PAIR, pc=0.
- Address mux (combinational), priority order:
  1. state=HALT: imem_en=0, address don't-care.
  2. branch_flag=1: imem_addr=branch_pc[IMEM_ADDR_W-1:0].
  3. interlock=1 and rd_valid=1: imem_addr=rd_pc (re-read the displayed word so it stays stable).
  4. Otherwise: imem_addr=nxt_pc.
  - imem_en=1 in all non-HALT cases.
- Register update each clk (non-HALT), same priority:
  - branch_flag: rd_pc<=branch_pc, nxt_pc<=branch_pc+1, rd_valid<=1, state<=RUN. Any interlock that cycle is ignored.
  - interlock: hold nxt_pc, rd_pc, rd_valid and state.
  - Otherwise: rd_pc<=nxt_pc, nxt_pc<=nxt_pc+1, rd_valid<=1, state<=RUN.
- Latency:
  - First valid pair appears the 2nd cycle after reset release.
  - Target pair appears the cycle after branch_flag. The pair shown during branch_flag is discarded by decode; no further bubble.
- Halt:
  - Trigger: inst[63:58]==End, rd_valid=1, interlock=0, branch_flag=0 (accepted).
  - Next cycle: state<=HALT, halted<=1, rd_valid<=0. inst stays NOP_PAIR and imem_en=0 until reset.
  - If branch_flag coincides with a displayed End, the branch wins and there is no halt.
  - branch_flag or interlock while in HALT: ignored.
- Arithmetic:
  - PCs are 32-bit and wrap modulo 2^32 (32'hFFFFFFFF+1=0).
  - imem_addr takes the low IMEM_ADDR_W bits; upper bits are ignored, so memory aliases.
- Interlock in BOOT (rd_valid=0): outputs stay NOP_PAIR and nxt_pc does not advance.
- Reset asserted mid-stall, mid-redirect or in HALT: all state returns to reset values asynchronously; no pending redirect survives.

Decomposition:
- inst_package gains:
  - NOP_PAIR = {Nop,26'b0,Nop,26'b0}.
  - fetch_state_t enum {BOOT, RUN, HALT}.
  - Existing opcodes Nop and End are reused.
- IMEM_ADDR_W default lives as a package constant shared with the memory wrapper.
- No sub-module; the block is one FSM plus two muxes. The instruction BRAM stays outside.

Test Plan:
- Reset release, imem[0..3]=A,B,C,D, BOOT_PC=0 -> cycle1 inst=NOP_PAIR/pc=0; cycles2..5 show A/0, B/1, C/2, D/3.
- Interlock high 3 cycles while B/1 displayed -> inst=B, pc=1 held every stall cycle; imem_addr=1 during stall; C/2 appears the cycle after release.
- branch_flag=1, branch_pc=0x40 while C/2 displayed -> imem_addr=0x40 that cycle; next cycle inst=imem[0x40], pc=0x40; then 0x41.
- branch_flag and interlock both high -> redirect taken exactly as above.
- imem[5] upper opcode End, no stall -> End/5 shown one cycle; then halted=1, inst=NOP_PAIR, imem_en=0 indefinitely. Same with branch_flag coincident -> no halt.
- nxt_pc=32'hFFFFFFFF, IMEM_ADDR_W=14 -> imem_addr=0x3FFF, then pc wraps to 0, imem_addr=0. Async rstn pulse mid-stall -> outputs return to NOP_PAIR/0 immediately.
